// File: rtl/ws2812_receiver.sv
// WS2812 single-wire stream decoder: classifies synchronized high-pulse widths into
// bits, assembles 24-bit pixels MSB-first, and reports latch gaps and malformed input.
module ws2812_receiver #(
    parameter int GLITCH_CYCLES   = 2,
    parameter int ONE_THRESHOLD   = 8,
    parameter int MAX_HIGH_CYCLES = 24,
    parameter int RESET_CYCLES    = 600,
    parameter int INDEX_WIDTH     = 10
) (
    input  logic                   clock_12mhz,
    input  logic                   reset_n,
    input  logic                   din,
    output logic [23:0]            pixel_data,
    output logic                   pixel_valid,
    output logic [INDEX_WIDTH-1:0] pixel_index,
    output logic                   frame_done,
    output logic                   protocol_error,
    output logic                   busy
);
    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam int HW = $clog2(MAX_HIGH_CYCLES + 1);

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t                 r_state;
    logic                   r_din_meta;
    logic                   r_din_sync;
    logic [LW-1:0]          r_low_count;
    logic [HW-1:0]          r_high_count;
    logic [23:0]            r_shift;
    logic [4:0]             r_bit_count;
    logic [INDEX_WIDTH-1:0] r_pix_count;
    logic                   r_have_pix;
    logic                   r_load;

    logic [LW-1:0] w_low_next;
    logic [HW-1:0] w_high_next;
    logic          w_low_done;
    logic          w_high_done;
    logic          w_bit;

    // Both counters saturate at their terminal value instead of wrapping.
    assign w_low_next  = (r_low_count == LW'(RESET_CYCLES)) ? r_low_count : r_low_count + 1'b1;
    assign w_high_next = (r_high_count == HW'(MAX_HIGH_CYCLES)) ? r_high_count : r_high_count + 1'b1;
    assign w_low_done  = (w_low_next == LW'(RESET_CYCLES));
    assign w_high_done = (w_high_next == HW'(MAX_HIGH_CYCLES));
    assign w_bit       = (r_high_count >= HW'(ONE_THRESHOLD));
    assign busy        = (r_state == ST_HIGH) || (r_state == ST_LOW);

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_SYNC;
            r_din_meta     <= 1'b0;
            r_din_sync     <= 1'b0;
            r_low_count    <= '0;
            r_high_count   <= '0;
            r_shift        <= '0;
            r_bit_count    <= '0;
            r_pix_count    <= '0;
            r_have_pix     <= 1'b0;
            r_load         <= 1'b0;
            pixel_data     <= '0;
            pixel_valid    <= 1'b0;
            pixel_index    <= '0;
            frame_done     <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            r_din_meta     <= din;
            r_din_sync     <= r_din_meta;
            pixel_valid    <= 1'b0;
            frame_done     <= 1'b0;
            protocol_error <= 1'b0;
            r_load         <= 1'b0;

            // Pixel publish runs one cycle after the 24th falling edge.
            if (r_load) begin
                pixel_data  <= r_shift;
                pixel_valid <= 1'b1;
                pixel_index <= r_pix_count;
                r_pix_count <= r_pix_count + 1'b1;
                r_have_pix  <= 1'b1;
                r_bit_count <= '0;
            end

            case (r_state)
                ST_SYNC: begin
                    if (r_din_sync) begin
                        r_low_count <= '0;
                    end else begin
                        r_low_count <= w_low_next;
                        if (w_low_done) r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (r_din_sync) begin
                        r_high_count <= HW'(1);
                        r_state      <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (r_din_sync) begin
                        r_high_count <= w_high_next;
                        if (w_high_done) begin
                            protocol_error <= 1'b1;
                            r_bit_count    <= '0;
                            r_pix_count    <= '0;
                            r_have_pix     <= 1'b0;
                            r_low_count    <= '0;
                            r_state        <= ST_SYNC;
                        end
                    end else begin
                        r_low_count <= '0;
                        r_state     <= ST_LOW;
                        if (r_high_count >= HW'(GLITCH_CYCLES)) begin
                            r_shift     <= {r_shift[22:0], w_bit};
                            r_bit_count <= r_bit_count + 1'b1;
                            if (r_bit_count == 5'd23) r_load <= 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    if (r_din_sync) begin
                        r_high_count <= HW'(1);
                        r_state      <= ST_HIGH;
                    end else begin
                        r_low_count <= w_low_next;
                        if (w_low_done) begin
                            protocol_error <= (r_bit_count != 5'd0);
                            frame_done     <= r_have_pix;
                            r_bit_count    <= '0;
                            r_pix_count    <= '0;
                            r_have_pix     <= 1'b0;
                            r_state        <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_SYNC;
            endcase
        end
    end
endmodule
